// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared parameters and FSM encoding for the interrupt controller
package irq_pkg;

    localparam int NUM_SRC_DEF = 4;
    localparam int VEC_W_DEF   = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } irq_state_e;

endpackage

// File: rtl/interrupt_controller_if.sv
// rtl/interrupt_controller_if.sv - CPU/source signal bundle for the interrupt controller
interface interrupt_controller_if
    import irq_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int VEC_W   = VEC_W_DEF
);

    logic [NUM_SRC-1:0] iIrq;
    logic               iMaskWr;
    logic [NUM_SRC-1:0] iMaskData;
    logic               iAck;
    logic               iEoi;
    logic               iOvrClr;
    logic               oIRQ;
    logic [VEC_W-1:0]   oVector;
    logic [NUM_SRC-1:0] oPending;
    logic [NUM_SRC-1:0] oOverrun;

    modport master (
        output iIrq, iMaskWr, iMaskData, iAck, iEoi, iOvrClr,
        input  oIRQ, oVector, oPending, oOverrun
    );

    modport slave (
        input  iIrq, iMaskWr, iMaskData, iAck, iEoi, iOvrClr,
        output oIRQ, oVector, oPending, oOverrun
    );

endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest set bit wins
module irq_prio_enc
    import irq_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int VEC_W   = VEC_W_DEF
) (
    input  logic [NUM_SRC-1:0] req_i,
    output logic               valid_o,
    output logic [VEC_W-1:0]   index_o
);

    always_comb begin
        valid_o = |req_i;
        index_o = '0;
        // Scan downward so the lowest asserted index is the last one written.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                index_o = VEC_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_controller.sv
// rtl/interrupt_controller.sv - pending/mask/overrun registers and IDLE/REQ/SERVICE handshake FSM
module interrupt_controller
    import irq_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int VEC_W   = VEC_W_DEF
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [NUM_SRC-1:0] iIrq,
    input  logic               iMaskWr,
    input  logic [NUM_SRC-1:0] iMaskData,
    input  logic               iAck,
    input  logic               iEoi,
    input  logic               iOvrClr,
    output logic               oIRQ,
    output logic [VEC_W-1:0]   oVector,
    output logic [NUM_SRC-1:0] oPending,
    output logic [NUM_SRC-1:0] oOverrun
);

    irq_state_e         state_q, state_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] mask_q, mask_d;
    logic [NUM_SRC-1:0] overrun_q, overrun_d;
    logic [VEC_W-1:0]   vector_q, vector_d;
    logic               irq_q, irq_d;

    logic               elig_valid;
    logic [VEC_W-1:0]   elig_idx;
    logic               ack_fire;
    logic [NUM_SRC-1:0] ack_vec;

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC),
        .VEC_W   (VEC_W)
    ) u_prio_enc (
        .req_i   (pending_q & mask_q),
        .valid_o (elig_valid),
        .index_o (elig_idx)
    );

    always_comb begin
        state_d  = state_q;
        vector_d = vector_q;
        ack_fire = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (elig_valid) begin
                    state_d  = ST_REQ;
                    vector_d = elig_idx;
                end
            end
            ST_REQ: begin
                // Masking the latched source withdraws the request without touching pending.
                if (!mask_q[vector_q]) begin
                    state_d = ST_IDLE;
                end else if (iAck) begin
                    state_d  = ST_SERVICE;
                    ack_fire = 1'b1;
                end
            end
            ST_SERVICE: begin
                if (iEoi) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        irq_d = (state_d == ST_REQ);
    end

    // A request arriving on the acknowledged source in the ack cycle re-arms it cleanly.
    always_comb begin
        ack_vec   = ack_fire ? (NUM_SRC'(1) << vector_q) : '0;
        pending_d = (pending_q & ~ack_vec) | iIrq;
        overrun_d = (iOvrClr ? '0 : overrun_q) | (iIrq & pending_q & ~ack_vec);
        mask_d    = iMaskWr ? iMaskData : mask_q;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            mask_q    <= '1;
            overrun_q <= '0;
            vector_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            overrun_q <= overrun_d;
            vector_q  <= vector_d;
            irq_q     <= irq_d;
        end
    end

    assign oIRQ     = irq_q;
    assign oVector  = vector_q;
    assign oPending = pending_q;
    assign oOverrun = overrun_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// tb/tb_interrupt_controller.sv - directed self-checking bench for interrupt_controller
module tb_interrupt_controller;
    import irq_pkg::*;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    interrupt_controller_if #(.NUM_SRC(4), .VEC_W(2)) bus ();

    interrupt_controller #(.NUM_SRC(4), .VEC_W(2)) dut (
        .iCLK      (clk),
        .iRST      (rst),
        .iIrq      (bus.iIrq),
        .iMaskWr   (bus.iMaskWr),
        .iMaskData (bus.iMaskData),
        .iAck      (bus.iAck),
        .iEoi      (bus.iEoi),
        .iOvrClr   (bus.iOvrClr),
        .oIRQ      (bus.oIRQ),
        .oVector   (bus.oVector),
        .oPending  (bus.oPending),
        .oOverrun  (bus.oOverrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst           = 1'b1;
        bus.iIrq      = 4'b0000;
        bus.iMaskWr   = 1'b0;
        bus.iMaskData = 4'b0000;
        bus.iAck      = 1'b0;
        bus.iEoi      = 1'b0;
        bus.iOvrClr   = 1'b0;
        tick();
        tick();
        chk("rst_irq", 32'(bus.oIRQ), 32'd0);
        chk("rst_vec", 32'(bus.oVector), 32'd0);
        chk("rst_pend", 32'(bus.oPending), 32'h0);
        chk("rst_ovr", 32'(bus.oOverrun), 32'h0);
        rst = 1'b0;

        // Basic latency and ack on source 0
        bus.iIrq = 4'b0001; tick(); bus.iIrq = 4'b0000;
        chk("lat1_irq", 32'(bus.oIRQ), 32'd0);
        chk("lat1_pend", 32'(bus.oPending), 32'h1);
        tick();
        chk("lat2_irq", 32'(bus.oIRQ), 32'd1);
        chk("lat2_vec", 32'(bus.oVector), 32'd0);
        bus.iAck = 1'b1; tick(); bus.iAck = 1'b0;
        chk("ack_pend", 32'(bus.oPending), 32'h0);
        chk("ack_irq", 32'(bus.oIRQ), 32'd0);
        bus.iEoi = 1'b1; tick(); bus.iEoi = 1'b0;

        // Priority: 1010 serves vector 1 then vector 3
        bus.iIrq = 4'b1010; tick(); bus.iIrq = 4'b0000;
        chk("pri_pend", 32'(bus.oPending), 32'hA);
        tick();
        chk("pri_irq1", 32'(bus.oIRQ), 32'd1);
        chk("pri_vec1", 32'(bus.oVector), 32'd1);
        bus.iIrq = 4'b0001; tick(); bus.iIrq = 4'b0000;
        chk("pri_hold_vec", 32'(bus.oVector), 32'd1);
        bus.iAck = 1'b1; tick(); bus.iAck = 1'b0;
        chk("pri_svc_pend", 32'(bus.oPending), 32'h9);
        chk("pri_svc_vec", 32'(bus.oVector), 32'd1);
        bus.iEoi = 1'b1; tick(); bus.iEoi = 1'b0;
        chk("pri_eoi_gap", 32'(bus.oIRQ), 32'd0);
        tick();
        chk("pri_irq0", 32'(bus.oIRQ), 32'd1);
        chk("pri_vec0", 32'(bus.oVector), 32'd0);
        bus.iAck = 1'b1; tick(); bus.iAck = 1'b0;
        bus.iEoi = 1'b1; tick(); bus.iEoi = 1'b0;
        tick();
        chk("pri_irq3", 32'(bus.oIRQ), 32'd1);
        chk("pri_vec3", 32'(bus.oVector), 32'd3);
        bus.iAck = 1'b1; tick(); bus.iAck = 1'b0;
        bus.iEoi = 1'b1; tick(); bus.iEoi = 1'b0;
        chk("pri_done_pend", 32'(bus.oPending), 32'h0);

        // Masking while idle and while requesting
        bus.iMaskWr = 1'b1; bus.iMaskData = 4'b1110; tick(); bus.iMaskWr = 1'b0;
        bus.iIrq = 4'b0001; tick(); bus.iIrq = 4'b0000;
        tick(); tick();
        chk("msk_irq", 32'(bus.oIRQ), 32'd0);
        chk("msk_pend", 32'(bus.oPending), 32'h1);
        bus.iMaskWr = 1'b1; bus.iMaskData = 4'b1111; tick(); bus.iMaskWr = 1'b0;
        chk("unmsk_irq1", 32'(bus.oIRQ), 32'd0);
        tick();
        chk("unmsk_irq2", 32'(bus.oIRQ), 32'd1);
        chk("unmsk_vec", 32'(bus.oVector), 32'd0);
        bus.iMaskWr = 1'b1; bus.iMaskData = 4'b1110; tick(); bus.iMaskWr = 1'b0;
        tick();
        chk("reqmsk_irq", 32'(bus.oIRQ), 32'd0);
        chk("reqmsk_pend", 32'(bus.oPending), 32'h1);
        bus.iMaskWr = 1'b1; bus.iMaskData = 4'b1111; tick(); bus.iMaskWr = 1'b0;
        tick();
        chk("reqmsk_rearm", 32'(bus.oIRQ), 32'd1);
        bus.iAck = 1'b1; tick(); bus.iAck = 1'b0;
        bus.iEoi = 1'b1; tick(); bus.iEoi = 1'b0;

        // Overrun set, clear, and set-wins-over-clear
        bus.iIrq = 4'b0100; tick(); bus.iIrq = 4'b0000;
        tick();
        chk("ovr_vec", 32'(bus.oVector), 32'd2);
        bus.iIrq = 4'b0100; tick(); bus.iIrq = 4'b0000;
        chk("ovr_set", 32'(bus.oOverrun), 32'h4);
        bus.iOvrClr = 1'b1; tick(); bus.iOvrClr = 1'b0;
        chk("ovr_clr", 32'(bus.oOverrun), 32'h0);
        bus.iOvrClr = 1'b1; bus.iIrq = 4'b0100; tick();
        bus.iOvrClr = 1'b0; bus.iIrq = 4'b0000;
        chk("ovr_setwins", 32'(bus.oOverrun), 32'h4);
        bus.iOvrClr = 1'b1; tick(); bus.iOvrClr = 1'b0;
        bus.iAck = 1'b1; tick(); bus.iAck = 1'b0;
        bus.iEoi = 1'b1; tick(); bus.iEoi = 1'b0;
        chk("ovr_done_pend", 32'(bus.oPending), 32'h0);

        // Simultaneous ack and re-pulse on the served source
        bus.iIrq = 4'b0001; tick(); bus.iIrq = 4'b0000;
        tick();
        bus.iIrq = 4'b0001; bus.iAck = 1'b1; tick();
        bus.iIrq = 4'b0000; bus.iAck = 1'b0;
        chk("ackset_pend", 32'(bus.oPending), 32'h1);
        chk("ackset_ovr", 32'(bus.oOverrun), 32'h0);
        chk("ackset_irq", 32'(bus.oIRQ), 32'd0);
        bus.iEoi = 1'b1; tick(); bus.iEoi = 1'b0;
        chk("ackset_gap", 32'(bus.oIRQ), 32'd0);
        tick();
        chk("ackset_rereq", 32'(bus.oIRQ), 32'd1);
        chk("ackset_vec", 32'(bus.oVector), 32'd0);
        bus.iAck = 1'b1; tick(); bus.iAck = 1'b0;

        // Reset while in SERVICE, stray EOI afterwards
        bus.iIrq = 4'b0010; tick(); bus.iIrq = 4'b0000;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("svcrst_irq", 32'(bus.oIRQ), 32'd0);
        chk("svcrst_vec", 32'(bus.oVector), 32'd0);
        chk("svcrst_pend", 32'(bus.oPending), 32'h0);
        chk("svcrst_ovr", 32'(bus.oOverrun), 32'h0);
        bus.iEoi = 1'b1; tick(); bus.iEoi = 1'b0;
        chk("svcrst_eoi", 32'(bus.oIRQ), 32'd0);

        // Inputs ignored during reset; ack ignored in IDLE
        rst = 1'b1; bus.iIrq = 4'b1111; bus.iMaskWr = 1'b1; bus.iMaskData = 4'b0000; tick();
        rst = 1'b0; bus.iIrq = 4'b0000; bus.iMaskWr = 1'b0;
        chk("rstin_pend", 32'(bus.oPending), 32'h0);
        bus.iIrq = 4'b0100; bus.iAck = 1'b1; tick();
        bus.iIrq = 4'b0000; bus.iAck = 1'b0;
        chk("idleack_pend", 32'(bus.oPending), 32'h4);
        tick();
        chk("rstmask_irq", 32'(bus.oIRQ), 32'd1);
        chk("rstmask_vec", 32'(bus.oVector), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
